// File: rtl/decode_stage_if.sv
// decode_stage_if: IF -> ID -> EX handshake and control bundle for the decode stage
// Ports (signals):
//   if_valid/if_instr/if_pc : instruction offered by IF
//   id_ready                : decode stage accepts the offered instruction
//   ex_ready/flush          : EX back-pressure and branch/jump squash
//   ex_valid..illegal       : registered ID/EX contents consumed by EX, M, WB
//   stall_cnt               : load-use bubbles inserted since reset
// Modports: master = IF/EX side, slave = decode stage.
interface decode_stage_if #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
);
    logic             if_valid;
    logic [31:0]      if_instr;
    logic [XLEN-1:0]  if_pc;
    logic             id_ready;
    logic             ex_ready;
    logic             flush;
    logic             ex_valid;
    logic [XLEN-1:0]  ex_pc;
    logic [4:0]       Rd;
    logic [4:0]       Ra;
    logic [4:0]       Rb;
    logic [2:0]       Extop;
    logic             ALUASrc;
    logic [1:0]       ALUBSrc;
    logic [3:0]       ALUctr;
    logic             MemWr;
    logic             Jump;
    logic             MemtoReg;
    logic             RegWr;
    logic [1:0]       Branch;
    logic             illegal;
    logic [CNT_W-1:0] stall_cnt;

    modport master (
        output if_valid, if_instr, if_pc, ex_ready, flush,
        input  id_ready, ex_valid, ex_pc, Rd, Ra, Rb, Extop, ALUASrc, ALUBSrc, ALUctr,
               MemWr, Jump, MemtoReg, RegWr, Branch, illegal, stall_cnt
    );

    modport slave (
        input  if_valid, if_instr, if_pc, ex_ready, flush,
        output id_ready, ex_valid, ex_pc, Rd, Ra, Rb, Extop, ALUASrc, ALUBSrc, ALUctr,
               MemWr, Jump, MemtoReg, RegWr, Branch, illegal, stall_cnt
    );
endinterface

// File: rtl/decode_stage.sv
// decode_stage: RV32 decode into the ID/EX register with load-use bubble insertion and flush
// Ports:
//   clk    : rising-edge clock
//   Resetn : synchronous active-low reset
//   bus    : decode_stage_if.slave (IF handshake, EX handshake/flush, registered control bundle)
module decode_stage #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  logic           clk,
    input  logic           Resetn,
    decode_stage_if.slave  bus
);
    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] pc;
        logic [4:0]      rd;
        logic [4:0]      ra;
        logic [4:0]      rb;
        logic [2:0]      extop;
        logic            asrc;
        logic [1:0]      bsrc;
        logic [3:0]      aluctr;
        logic            memwr;
        logic            jump;
        logic            mtr;
        logic            regwr;
        logic [1:0]      branch;
        logic            illegal;
    } ctrl_t;

    ctrl_t            r_idex;
    ctrl_t            w_dec;
    logic [CNT_W-1:0] r_stall_cnt;
    logic             w_use1;
    logic             w_use2;
    logic             w_hazard;
    logic             w_advance;
    logic [6:0]       w_op;
    logic [2:0]       w_f3;
    logic [6:0]       w_f7;

    assign w_op = bus.if_instr[6:0];
    assign w_f3 = bus.if_instr[14:12];
    assign w_f7 = bus.if_instr[31:25];

    // Undecodable words keep only valid/pc/register fields; all controls stay 0.
    always_comb begin
        w_dec         = '0;
        w_use1        = 1'b0;
        w_use2        = 1'b0;
        w_dec.valid   = 1'b1;
        w_dec.pc      = bus.if_pc;
        w_dec.rd      = bus.if_instr[11:7];
        w_dec.ra      = bus.if_instr[19:15];
        w_dec.rb      = bus.if_instr[24:20];
        w_dec.illegal = 1'b1;
        case (w_op)
            7'b0110011: if ((w_f7 == 7'b0000000 && w_f3 != 3'b001 && w_f3 != 3'b101) ||
                            (w_f7 == 7'b0100000 && w_f3 == 3'b000)) begin
                w_dec.illegal = 1'b0;
                // ALUctr low bits line up with funct3 for slt..and
                w_dec.aluctr  = w_f7[5] ? 4'b0001 : {1'b0, w_f3};
                w_dec.regwr   = 1'b1;
                w_use1        = 1'b1;
                w_use2        = 1'b1;
            end
            7'b0010011: if (w_f3 != 3'b001 && w_f3 != 3'b101) begin
                w_dec.illegal = 1'b0;
                w_dec.aluctr  = {1'b0, w_f3};
                w_dec.bsrc    = 2'b10;
                w_dec.regwr   = 1'b1;
                w_use1        = 1'b1;
            end
            7'b0110111: begin
                w_dec.illegal = 1'b0;
                w_dec.extop   = 3'b001;
                w_dec.bsrc    = 2'b10;
                w_dec.aluctr  = 4'b1111;
                w_dec.regwr   = 1'b1;
            end
            7'b0000011: if (w_f3 == 3'b010) begin
                w_dec.illegal = 1'b0;
                w_dec.bsrc    = 2'b10;
                w_dec.mtr     = 1'b1;
                w_dec.regwr   = 1'b1;
                w_use1        = 1'b1;
            end
            7'b0100011: if (w_f3 == 3'b010) begin
                w_dec.illegal = 1'b0;
                w_dec.extop   = 3'b010;
                w_dec.bsrc    = 2'b10;
                w_dec.memwr   = 1'b1;
                w_use1        = 1'b1;
                w_use2        = 1'b1;
            end
            7'b1100011: if (w_f3 == 3'b000 || w_f3 == 3'b001) begin
                w_dec.illegal = 1'b0;
                w_dec.extop   = 3'b011;
                w_dec.aluctr  = 4'b1000;
                w_dec.branch  = w_f3[0] ? 2'b10 : 2'b01;
                w_use1        = 1'b1;
                w_use2        = 1'b1;
            end
            7'b1101111: begin
                w_dec.illegal = 1'b0;
                w_dec.extop   = 3'b100;
                w_dec.asrc    = 1'b1;
                w_dec.bsrc    = 2'b01;
                w_dec.jump    = 1'b1;
                w_dec.regwr   = 1'b1;
            end
            default: ;
        endcase
        if (w_dec.rd == 5'd0) w_dec.regwr = 1'b0;
    end

    assign w_hazard  = r_idex.valid & r_idex.mtr & (r_idex.rd != 5'd0) &
                       (((r_idex.rd == w_dec.ra) & w_use1) | ((r_idex.rd == w_dec.rb) & w_use2));
    assign w_advance = ~r_idex.valid | bus.ex_ready;

    always_ff @(posedge clk) begin
        if (!Resetn) begin
            r_idex      <= '0;
            r_stall_cnt <= '0;
        end else if (bus.flush) begin
            r_idex      <= '0;
        end else if (w_advance) begin
            r_idex      <= (bus.if_valid & ~w_hazard) ? w_dec : '0;
            if (bus.if_valid && w_hazard && r_stall_cnt != '1)
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
        end
    end

    assign bus.id_ready  = (w_advance & ~w_hazard) | bus.flush;
    assign bus.ex_valid  = r_idex.valid;
    assign bus.ex_pc     = r_idex.pc;
    assign bus.Rd        = r_idex.rd;
    assign bus.Ra        = r_idex.ra;
    assign bus.Rb        = r_idex.rb;
    assign bus.Extop     = r_idex.extop;
    assign bus.ALUASrc   = r_idex.asrc;
    assign bus.ALUBSrc   = r_idex.bsrc;
    assign bus.ALUctr    = r_idex.aluctr;
    assign bus.MemWr     = r_idex.memwr;
    assign bus.Jump      = r_idex.jump;
    assign bus.MemtoReg  = r_idex.mtr;
    assign bus.RegWr     = r_idex.regwr;
    assign bus.Branch    = r_idex.branch;
    assign bus.illegal   = r_idex.illegal;
    assign bus.stall_cnt = r_stall_cnt;
endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: directed self-checking bench for decode_stage
module tb_decode_stage;
    localparam logic [31:0] ADD_3_1_2 = 32'h002081B3;
    localparam logic [31:0] SUB_4_3_1 = 32'h40118233;
    localparam logic [31:0] ORI_5_0_7 = 32'h00706293;
    localparam logic [31:0] LW_5_1    = 32'h0000A283;
    localparam logic [31:0] ADD_6_5_2 = 32'h00228333;
    localparam logic [31:0] LW_0_1    = 32'h0000A003;
    localparam logic [31:0] ADD_7_0_2 = 32'h002003B3;
    localparam logic [31:0] BEQ_1_2   = 32'h00208063;
    localparam logic [31:0] SW_2_1    = 32'h0020A023;
    localparam logic [31:0] LUI_8     = 32'h12345437;
    localparam logic [31:0] JAL_1     = 32'h000000EF;
    localparam logic [31:0] BAD_OP    = 32'h0000007F;
    localparam logic [31:0] MUL_3_1_2 = 32'h022081B3;

    logic clk = 1'b0;
    logic Resetn;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    decode_stage_if #(.XLEN(32), .CNT_W(16)) bus ();
    decode_stage #(.XLEN(32), .CNT_W(16)) dut (.clk(clk), .Resetn(Resetn), .bus(bus));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [31:0] instr, input logic [31:0] pc);
        bus.if_valid = v;
        bus.if_instr = instr;
        bus.if_pc    = pc;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        Resetn       = 1'b0;
        bus.ex_ready = 1'b1;
        bus.flush    = 1'b0;
        drive(1'b1, JAL_1, 32'h80);
        tick();
        tick();
        chk("rst_valid", 32'(bus.ex_valid), 0);
        chk("rst_jump", 32'(bus.Jump), 0);
        chk("rst_regwr", 32'(bus.RegWr), 0);
        chk("rst_pc", bus.ex_pc, 0);
        chk("rst_alubsrc", 32'(bus.ALUBSrc), 0);
        chk("rst_cnt", 32'(bus.stall_cnt), 0);

        Resetn = 1'b1;
        drive(1'b1, ADD_3_1_2, 32'h100);
        tick();
        chk("add_valid", 32'(bus.ex_valid), 1);
        chk("add_pc", bus.ex_pc, 32'h100);
        chk("add_rd", 32'(bus.Rd), 3);
        chk("add_ra_rb", {bus.Ra, bus.Rb}, {5'd1, 5'd2});
        chk("add_aluctr", 32'(bus.ALUctr), 4'b0000);
        chk("add_bsrc", 32'(bus.ALUBSrc), 2'b00);
        chk("add_regwr", 32'(bus.RegWr), 1);
        drive(1'b1, SUB_4_3_1, 32'h104);
        tick();
        chk("sub_aluctr", 32'(bus.ALUctr), 4'b0001);
        chk("sub_bsrc", 32'(bus.ALUBSrc), 2'b00);
        chk("sub_regwr", 32'(bus.RegWr), 1);
        drive(1'b1, ORI_5_0_7, 32'h108);
        tick();
        chk("ori_aluctr", 32'(bus.ALUctr), 4'b0110);
        chk("ori_bsrc", 32'(bus.ALUBSrc), 2'b10);
        chk("ori_extop", 32'(bus.Extop), 3'b000);
        chk("ori_regwr", 32'(bus.RegWr), 1);

        drive(1'b1, LW_5_1, 32'h10C);
        tick();
        chk("lw_mtr", 32'(bus.MemtoReg), 1);
        chk("lw_regwr", 32'(bus.RegWr), 1);
        chk("lw_bsrc", 32'(bus.ALUBSrc), 2'b10);
        drive(1'b1, ADD_6_5_2, 32'h110);
        #1;
        chk("hz_id_ready", 32'(bus.id_ready), 0);
        tick();
        chk("hz_bubble", 32'(bus.ex_valid), 0);
        chk("hz_bubble_regwr", 32'(bus.RegWr), 0);
        chk("hz_bubble_mtr", 32'(bus.MemtoReg), 0);
        chk("hz_cnt", 32'(bus.stall_cnt), 1);
        chk("hz_ready_after", 32'(bus.id_ready), 1);
        tick();
        chk("dep_valid", 32'(bus.ex_valid), 1);
        chk("dep_rd", 32'(bus.Rd), 6);
        chk("dep_pc", bus.ex_pc, 32'h110);
        chk("dep_cnt", 32'(bus.stall_cnt), 1);

        drive(1'b1, LW_0_1, 32'h114);
        tick();
        chk("lw0_regwr", 32'(bus.RegWr), 0);
        chk("lw0_mtr", 32'(bus.MemtoReg), 1);
        drive(1'b1, ADD_7_0_2, 32'h118);
        #1;
        chk("x0_id_ready", 32'(bus.id_ready), 1);
        tick();
        chk("x0_valid", 32'(bus.ex_valid), 1);
        chk("x0_rd", 32'(bus.Rd), 7);
        chk("x0_cnt", 32'(bus.stall_cnt), 1);

        drive(1'b1, BEQ_1_2, 32'h11C);
        tick();
        chk("beq_branch", 32'(bus.Branch), 2'b01);
        chk("beq_aluctr", 32'(bus.ALUctr), 4'b1000);
        chk("beq_extop", 32'(bus.Extop), 3'b011);
        chk("beq_regwr", 32'(bus.RegWr), 0);
        drive(1'b1, SW_2_1, 32'h120);
        bus.flush = 1'b1;
        #1;
        chk("fl_id_ready", 32'(bus.id_ready), 1);
        tick();
        chk("fl_valid", 32'(bus.ex_valid), 0);
        chk("fl_memwr", 32'(bus.MemWr), 0);
        chk("fl_branch", 32'(bus.Branch), 0);
        bus.flush = 1'b0;
        drive(1'b0, 32'h0, 32'h0);
        tick();
        chk("idle_valid", 32'(bus.ex_valid), 0);
        chk("idle_memwr", 32'(bus.MemWr), 0);

        drive(1'b1, LW_5_1, 32'h124);
        tick();
        drive(1'b1, ADD_6_5_2, 32'h128);
        bus.flush = 1'b1;
        tick();
        chk("flhz_valid", 32'(bus.ex_valid), 0);
        chk("flhz_cnt", 32'(bus.stall_cnt), 1);
        bus.flush = 1'b0;

        drive(1'b1, LUI_8, 32'h200);
        tick();
        chk("lui_aluctr", 32'(bus.ALUctr), 4'b1111);
        chk("lui_extop", 32'(bus.Extop), 3'b001);
        chk("lui_bsrc", 32'(bus.ALUBSrc), 2'b10);
        bus.ex_ready = 1'b0;
        drive(1'b1, JAL_1, 32'h204);
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("bp_id_ready", 32'(bus.id_ready), 0);
            tick();
            chk("bp_pc", bus.ex_pc, 32'h200);
            chk("bp_aluctr", 32'(bus.ALUctr), 4'b1111);
            chk("bp_jump", 32'(bus.Jump), 0);
        end
        bus.ex_ready = 1'b1;
        tick();
        chk("jal_pc", bus.ex_pc, 32'h204);
        chk("jal_jump", 32'(bus.Jump), 1);
        chk("jal_asrc", 32'(bus.ALUASrc), 1);
        chk("jal_bsrc", 32'(bus.ALUBSrc), 2'b01);
        chk("jal_extop", 32'(bus.Extop), 3'b100);
        chk("jal_regwr", 32'(bus.RegWr), 1);

        drive(1'b1, BAD_OP, 32'h208);
        tick();
        chk("badop_illegal", 32'(bus.illegal), 1);
        chk("badop_valid", 32'(bus.ex_valid), 1);
        chk("badop_ctl", {bus.RegWr, bus.MemWr, bus.Branch, bus.Jump, bus.MemtoReg}, 0);
        drive(1'b1, MUL_3_1_2, 32'h20C);
        tick();
        chk("mul_illegal", 32'(bus.illegal), 1);
        chk("mul_valid", 32'(bus.ex_valid), 1);
        chk("mul_ctl", {bus.RegWr, bus.MemWr, bus.Branch, bus.Jump, bus.MemtoReg}, 0);
        chk("mul_aluctr", 32'(bus.ALUctr), 0);
        drive(1'b1, ADD_3_1_2, 32'h210);
        tick();
        chk("legal_again", 32'(bus.illegal), 0);

        Resetn = 1'b0;
        tick();
        chk("mrst_valid", 32'(bus.ex_valid), 0);
        chk("mrst_rd", 32'(bus.Rd), 0);
        chk("mrst_cnt", 32'(bus.stall_cnt), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
